// File: rtl/aes_stim_seq.sv
// aes_stim_seq: stimulus sequencer for the AES core family.
// Two Galois LFSRs supply plaintext and key. A small FSM issues a programmable
// number of launches with an optional idle gap between them. A delay line
// matched to the core latency flags when each result appears at the core output.
module aes_stim_seq #(
  parameter int                  DATA_W     = 128,
  parameter int                  LATENCY    = 21,
  parameter logic [DATA_W-1:0]   STATE_SEED = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF,
  parameter logic [DATA_W-1:0]   KEY_SEED   = 128'hCAFE_FEED_CAFE_FEED_CAFE_FEED_CAFE_FEED,
  parameter logic [DATA_W-1:0]   TAPS       = 128'h87,
  parameter int                  CNT_W      = 32
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_Start,
  input  logic [CNT_W-1:0]  i_Num_Tests,
  input  logic [7:0]        i_Gap,
  input  logic              i_Key_Mode,
  output logic [DATA_W-1:0] o_State,
  output logic [DATA_W-1:0] o_Key,
  output logic              o_Launch,
  output logic              o_Result_Valid,
  output logic              o_Busy,
  output logic              o_Done,
  output logic [CNT_W-1:0]  o_Launch_Count,
  output logic [CNT_W-1:0]  o_Result_Count
);

  // An all-zero seed would lock the LFSR at zero, so it is replaced by 1.
  localparam logic [DATA_W-1:0] ONE_W      = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] STATE_INIT = (STATE_SEED == '0) ? ONE_W : STATE_SEED;
  localparam logic [DATA_W-1:0] KEY_INIT   = (KEY_SEED == '0) ? ONE_W : KEY_SEED;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_GAP, S_DRAIN, S_DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    num_reg;
  logic [7:0]          gap_reg;
  logic [7:0]          gap_cnt_reg;
  logic                key_mode_reg;
  logic [DATA_W-1:0]   state_lfsr_reg;
  logic [DATA_W-1:0]   key_lfsr_reg;
  logic [CNT_W-1:0]    launch_cnt_reg;
  logic [CNT_W-1:0]    result_cnt_reg;
  logic [LATENCY-1:0]  delay_reg;
  logic                start_ok;
  logic                last_launch;
  logic                drain_done;

  function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] cur);
    return {cur[DATA_W-2:0], 1'b0} ^ (cur[DATA_W-1] ? TAPS : '0);
  endfunction

  assign start_ok    = (state_reg == S_IDLE) && i_Start;
  // Launch in flight this cycle is the last one when the post-increment count hits num.
  assign last_launch = (launch_cnt_reg + CNT_W'(1)) == num_reg;
  // Count the result arriving this cycle so DONE follows the final result directly.
  assign drain_done  = (result_cnt_reg + CNT_W'(o_Result_Valid)) == num_reg;

  assign o_State        = state_lfsr_reg;
  assign o_Key          = key_lfsr_reg;
  assign o_Result_Valid = delay_reg[LATENCY-1];
  assign o_Launch_Count = launch_cnt_reg;
  assign o_Result_Count = result_cnt_reg;

  // FSM state register.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_next = state_reg;
    o_Launch   = 1'b0;
    o_Busy     = 1'b1;
    o_Done     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        o_Busy = 1'b0;
        if (i_Start) state_next = (i_Num_Tests == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: state_next = S_RUN;
      S_RUN: begin
        o_Launch = 1'b1;
        if (last_launch)        state_next = S_DRAIN;
        else if (gap_reg != '0) state_next = S_GAP;
        else                    state_next = S_RUN;
      end
      S_GAP:   if (gap_cnt_reg == '0) state_next = S_RUN;
      S_DRAIN: if (drain_done) state_next = S_DONE;
      S_DONE: begin
        o_Done     = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Capture run parameters when a start is accepted.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      num_reg      <= '0;
      gap_reg      <= '0;
      key_mode_reg <= 1'b0;
    end else if (start_ok) begin
      num_reg      <= i_Num_Tests;
      gap_reg      <= i_Gap;
      key_mode_reg <= i_Key_Mode;
    end
  end

  // Gap countdown: loaded on each launch, runs gap-1 down to 0 while in GAP.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L)                 gap_cnt_reg <= '0;
    else if (state_reg == S_RUN)  gap_cnt_reg <= gap_reg - 8'd1;
    else if (state_reg == S_GAP)  gap_cnt_reg <= gap_cnt_reg - 8'd1;
  end

  // Plaintext and key LFSRs: reseed on LOAD, step after each launch.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_lfsr_reg <= STATE_INIT;
      key_lfsr_reg   <= KEY_INIT;
    end else if (state_reg == S_LOAD) begin
      state_lfsr_reg <= STATE_INIT;
      key_lfsr_reg   <= KEY_INIT;
    end else if (state_reg == S_RUN) begin
      state_lfsr_reg <= lfsr_step(state_lfsr_reg);
      if (!key_mode_reg) key_lfsr_reg <= lfsr_step(key_lfsr_reg);
    end
  end

  // Launch/result counters; cleared on any accepted start so a zero-length run reports 0.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      launch_cnt_reg <= '0;
      result_cnt_reg <= '0;
    end else if (start_ok || state_reg == S_LOAD) begin
      launch_cnt_reg <= '0;
      result_cnt_reg <= '0;
    end else begin
      if (o_Launch)       launch_cnt_reg <= launch_cnt_reg + CNT_W'(1);
      if (o_Result_Valid) result_cnt_reg <= result_cnt_reg + CNT_W'(1);
    end
  end

  // Latency-matched delay line: tap gi holds the launch flag from gi+1 cycles ago.
  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_delay
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L)                delay_reg[gi] <= 1'b0;
      else if (state_reg == S_LOAD) delay_reg[gi] <= 1'b0;
      else if (gi == 0)            delay_reg[gi] <= o_Launch;
      else                         delay_reg[gi] <= delay_reg[(gi == 0) ? 0 : gi-1];
    end
  end

endmodule

// File: doc/aes_stim_seq.md
Name: aes_stim_seq

Overview:
- Synthesisable stimulus sequencer that replaces hand-timed bench sequencing for the AES core family.
- Holds two parametrised Galois LFSRs, one for plaintext and one for key, and launches a programmable number of encryptions.
- Supports a programmable idle gap between launches and a fixed-key or random-key mode.
- Tracks in-flight operations through a latency-matched delay line, flags when each result is due at the core output, and signals completion after the last result drains.

Parameters:
- DATA_W, 128, width of state/key words and of both LFSRs.
- LATENCY, 21, cycles from launch cycle to the cycle the core output holds that launch's result (>=1).
- STATE_SEED, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF, plaintext LFSR seed (DATA_W bits).
- KEY_SEED, 128'hCAFE_FEED_CAFE_FEED_CAFE_FEED_CAFE_FEED, key LFSR seed (DATA_W bits).
- TAPS, 128'h87, Galois feedback mask (x^128+x^7+x^2+x+1).
- CNT_W, 32, width of test counters.

Ports:
- i_Clk  in  1  clock; all state on rising edge.
- i_Rst_L  in  1  asynchronous, active-low reset.
- i_Start  in  1  one-cycle start request; honoured only in IDLE.
- i_Num_Tests  in  CNT_W  launches to perform; sampled on accepted start.
- i_Gap  in  8  idle cycles inserted between launches; sampled on accepted start.
- i_Key_Mode  in  1  0 = key advances every launch, 1 = key fixed at KEY_SEED; sampled on accepted start.
- o_State  out  DATA_W  plaintext presented to core (registered).
- o_Key  out  DATA_W  key presented to core (registered).
- o_Launch  out  1  high for exactly the cycles where o_State/o_Key are a new test.
- o_Result_Valid  out  1  high when the core output holds a launched test's result.
- o_Busy  out  1  high in every state except IDLE.
- o_Done  out  1  one-cycle pulse after the final result.
- o_Launch_Count  out  CNT_W  launches issued this run.
- o_Result_Count  out  CNT_W  results flagged this run.

Behaviour:
- Reset values:
  - FSM = IDLE.
  - o_State = STATE_SEED; o_Key = KEY_SEED.
  - All other outputs 0; counters 0; delay line all 0.
- Reset takes effect immediately, including mid-run. No partial results are flagged after release.
- LFSR step: next = {cur[DATA_W-2:0],1'b0} ^ (cur[DATA_W-1] ? TAPS : 0).
  - A seed of all zeros is replaced by 1 at load.
- FSM states:
  - IDLE: o_Busy=0.
    - i_Start with i_Num_Tests=0 -> DONE.
    - i_Start with i_Num_Tests>0 -> LOAD.
    - i_Start while not in IDLE is ignored.
  - LOAD (1 cycle):
    - Reload both LFSRs from their seeds.
    - Clear both counters and the delay line.
    - -> RUN.
  - RUN (1 cycle):
    - o_Launch=1 with the current o_State/o_Key; launch count increments at the cycle end.
    - On that edge the state LFSR steps; the key LFSR steps only when key mode is 0.
    - If this launch is the last one -> DRAIN.
    - Else, if gap > 0 -> GAP; if gap = 0 -> RUN (back-to-back, one launch per cycle).
  - GAP: hold outputs for exactly gap cycles, o_Launch=0, then -> RUN.
  - DRAIN: o_Launch=0; wait until result count equals the sampled num_tests, then -> DONE.
  - DONE (1 cycle): o_Done=1, o_Busy=1, then -> IDLE. Counters hold their final values until the next LOAD.
- Result tracking:
  - Delay line of LATENCY flops shifts o_Launch every cycle.
  - o_Result_Valid = delay-line tail, i.e. asserted exactly LATENCY cycles after each o_Launch.
  - Result count increments whenever o_Result_Valid=1.
- Counter width: CNT_W wraps modulo 2^CNT_W. i_Num_Tests is unsigned. No saturation.
- Start coincident with reset deassertion: honoured on the first clock after release if in IDLE.

Test Plan:
- Reset, start with num=1, gap=0, mode=0:
  - o_Launch at cycle 2 after start, with o_State=0xDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF and o_Key=0xCAFEFEED_CAFEFEED_CAFEFEED_CAFEFEED.
  - o_Result_Valid exactly 21 cycles later.
  - o_Done the cycle after, with both counts = 1.
- num=2, gap=0, mode=0:
  - Second launch on the next cycle with o_State=0xBD5B7DDF_BD5B7DDF_BD5B7DDF_BD5B7D59.
  - Two contiguous o_Result_Valid pulses.
- num=4, gap=3, mode=1:
  - Launches spaced 4 cycles apart; o_Key constant at KEY_SEED on every launch.
  - o_Result_Valid pulses spaced 4 apart; o_Done after the 4th result.
- num=0: o_Done pulses 1 cycle after start, no o_Launch, counts 0, back to IDLE.
- Pulse i_Start again during RUN of num=5: ignored; exactly 5 launches and 5 results.
- Assert i_Rst_L low for 1 cycle mid-DRAIN of num=3:
  - Outputs return to reset values immediately.
  - No o_Result_Valid or o_Done afterwards.
  - A fresh start then reproduces the first-launch values above.
